// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types and response codes.
// Used by both the master and the register-file slave.
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axi4lite_reg_array.sv
// Register storage: byte-strobed write port, combinational
// read port and a flattened view of every register.
module axi4lite_reg_array
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int NB = byte_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (waddr == ADDR_WIDTH'(i) && wstrb[b]) begin
            mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Unmapped indices read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        rdata = mem[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register bank with independent AW/W latches
// and a single-entry read response register.
module axi4lite_slave_regfile
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output resp_t                          s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output resp_t                          s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int NB = byte_lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(NUM_REGS);

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic [DATA_WIDTH-1:0] rd_data;

  assign s_awready = !rst && !aw_held && !s_bvalid;
  assign s_wready  = !rst && !w_held && !s_bvalid;
  assign s_arready = !rst && !s_rvalid;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // A channel arriving this cycle bypasses its latch.
  assign wr_addr = aw_hs ? s_awaddr : aw_addr;
  assign wr_data = w_hs ? s_wdata : w_data;
  assign wr_strb = w_hs ? s_wstrb : w_strb;

  assign commit = (aw_hs || aw_held) && (w_hs || w_held);
  assign wr_ok  = {1'b0, wr_addr} < LIMIT;
  assign rd_ok  = {1'b0, s_araddr} < LIMIT;
  assign we     = commit && wr_ok;

  axi4lite_reg_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .wstrb     (wr_strb),
    .raddr     (s_araddr),
    .rdata     (rd_data),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      s_bvalid <= 1'b1;
      s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Read samples the array before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_ok ? rd_data : '0;
      s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Random plus directed bench for axi4lite_slave_regfile,
// checked against a transaction-level model every cycle.
module tb_axi4lite_slave_regfile;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic          wstrb = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [NR*DW-1:0] regs_flat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4lite_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (awaddr),
    .s_awvalid (awvalid),
    .s_awready (awready),
    .s_wdata   (wdata),
    .s_wstrb   (wstrb),
    .s_wvalid  (wvalid),
    .s_wready  (wready),
    .s_bresp   (bresp),
    .s_bvalid  (bvalid),
    .s_bready  (bready),
    .s_araddr  (araddr),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_rdata   (rdata),
    .s_rresp   (rresp),
    .s_rvalid  (rvalid),
    .s_rready  (rready),
    .regs_flat (regs_flat)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model state: register contents, pending write halves,
  // outstanding B and R responses.
  logic [DW-1:0] m_regs [4] = '{default: '0};
  logic          m_aw = 1'b0;
  logic          m_w = 1'b0;
  logic [AW-1:0] m_awaddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_wstrb = 1'b0;
  logic          m_b = 1'b0;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_r = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = 2'b00;

  wire m_awrdy = !rst && !m_aw && !m_b;
  wire m_wrdy  = !rst && !m_w && !m_b;
  wire m_arrdy = !rst && !m_r;
  wire m_awh = awvalid && m_awrdy;
  wire m_wh  = wvalid && m_wrdy;
  wire m_arh = arvalid && m_arrdy;

  wire [AW-1:0] m_a = m_awh ? awaddr : m_awaddr;
  wire [DW-1:0] m_d = m_wh ? wdata : m_wdata;
  wire          m_s = m_wh ? wstrb : m_wstrb;
  wire m_done = (m_aw || m_awh) && (m_w || m_wh);
  wire m_wok  = int'(m_a) < NR;
  wire m_rok  = int'(araddr) < NR;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= '0;
      m_aw <= 1'b0;
      m_w  <= 1'b0;
      m_b  <= 1'b0;
      m_r  <= 1'b0;
      m_bresp <= 2'b00;
      m_rresp <= 2'b00;
      m_rdata <= '0;
    end else begin
      if (m_arh) begin
        m_r     <= 1'b1;
        m_rdata <= m_rok ? m_regs[araddr] : '0;
        m_rresp <= m_rok ? 2'b00 : 2'b10;
      end else if (m_r && rready) begin
        m_r <= 1'b0;
      end
      if (m_b && bready) m_b <= 1'b0;
      if (m_awh) begin
        m_aw     <= 1'b1;
        m_awaddr <= awaddr;
      end
      if (m_wh) begin
        m_w     <= 1'b1;
        m_wdata <= wdata;
        m_wstrb <= wstrb;
      end
      if (m_done) begin
        m_aw    <= 1'b0;
        m_w     <= 1'b0;
        m_b     <= 1'b1;
        m_bresp <= m_wok ? 2'b00 : 2'b10;
        if (m_wok && m_s) m_regs[m_a] <= m_d;
      end
    end
  end

  always @(negedge clk) begin
    chk("awready", 32'(awready), 32'(m_awrdy));
    chk("wready", 32'(wready), 32'(m_wrdy));
    chk("arready", 32'(arready), 32'(m_arrdy));
    chk("bvalid", 32'(bvalid), 32'(m_b));
    chk("bresp", 32'(bresp), 32'(m_bresp));
    chk("rvalid", 32'(rvalid), 32'(m_r));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("rresp", 32'(rresp), 32'(m_rresp));
    chk("regs_flat", 32'(regs_flat),
        32'({m_regs[2], m_regs[1], m_regs[0]}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_flat", 32'(regs_flat), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy",
        {29'd0, awready, wready, arready}, 32'd7);

    // AW and W together
    awaddr = 2'd2; awvalid = 1'b1;
    wdata = 8'h04; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    chk("t1_reg2", 32'(regs_flat[23:16]), 32'h04);
    bready = 1'b1; tick(); bready = 1'b0;
    araddr = 2'd2; arvalid = 1'b1; tick(); arvalid = 1'b0;
    chk("t1_rvalid", 32'(rvalid), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'h04);
    chk("t1_rresp", 32'(rresp), 32'd0);
    rready = 1'b1; tick(); rready = 1'b0;

    // W first, AW three cycles later
    wdata = 8'hA5; wvalid = 1'b1; tick(); wvalid = 1'b0;
    chk("t2_wready", 32'(wready), 32'd0);
    tick(); tick();
    chk("t2_nobvalid", 32'(bvalid), 32'd0);
    chk("t2_reg1_old", 32'(regs_flat[15:8]), 32'h00);
    awaddr = 2'd1; awvalid = 1'b1; tick(); awvalid = 1'b0;
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    chk("t2_reg1", 32'(regs_flat[15:8]), 32'hA5);
    bready = 1'b1; tick(); bready = 1'b0;

    // B stall with a second AW waiting
    awaddr = 2'd0; awvalid = 1'b1;
    wdata = 8'h11; wvalid = 1'b1; tick();
    wvalid = 1'b0; awaddr = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_bvalid", 32'(bvalid), 32'd1);
      chk("t3_rdy", {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    chk("t3_bdone", 32'(bvalid), 32'd0);
    chk("t3_awready", 32'(awready), 32'd1);
    tick(); awvalid = 1'b0;
    chk("t3_awheld", 32'(awready), 32'd0);
    wdata = 8'h77; wvalid = 1'b1; tick(); wvalid = 1'b0;
    bready = 1'b1; tick(); bready = 1'b0;
    chk("t3_flat", 32'(regs_flat), 32'h77A511);

    // Out of range address
    awaddr = 2'd3; awvalid = 1'b1;
    wdata = 8'hFF; wvalid = 1'b1; tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t4_bresp", 32'(bresp), 32'd2);
    chk("t4_flat", 32'(regs_flat), 32'h77A511);
    bready = 1'b1; tick(); bready = 1'b0;
    araddr = 2'd3; arvalid = 1'b1; tick(); arvalid = 1'b0;
    chk("t4_rresp", 32'(rresp), 32'd2);
    chk("t4_rdata", 32'(rdata), 32'd0);
    rready = 1'b1; tick(); rready = 1'b0;

    // Same-edge write and read of reg0
    awaddr = 2'd0; awvalid = 1'b1;
    wdata = 8'h33; wvalid = 1'b1;
    araddr = 2'd0; arvalid = 1'b1; tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5_rdata_old", 32'(rdata), 32'h11);
    chk("t5_reg0", 32'(regs_flat[7:0]), 32'h33);
    bready = 1'b1; rready = 1'b1; tick();
    bready = 1'b0; rready = 1'b0;
    arvalid = 1'b1; tick(); arvalid = 1'b0;
    chk("t5_rdata_new", 32'(rdata), 32'h33);
    rready = 1'b1; tick(); rready = 1'b0;

    // Reset mid-transaction
    araddr = 2'd1; arvalid = 1'b1; tick(); arvalid = 1'b0;
    awaddr = 2'd2; awvalid = 1'b1; tick(); awvalid = 1'b0;
    chk("t6_rvalid", 32'(rvalid), 32'd1);
    chk("t6_awheld", 32'(awready), 32'd0);
    rst = 1'b1; #1;
    chk("t6_rvalid0", 32'(rvalid), 32'd0);
    chk("t6_bvalid0", 32'(bvalid), 32'd0);
    chk("t6_flat0", 32'(regs_flat), 32'd0);
    tick(); rst = 1'b0; tick();
    chk("t6_rdy",
        {29'd0, awready, wready, arready}, 32'd7);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      awvalid = ($urandom_range(0, 2) != 0);
      awaddr  = AW'($urandom_range(0, 3));
      wvalid  = ($urandom_range(0, 2) != 0);
      wdata   = DW'($urandom);
      wstrb   = ($urandom_range(0, 3) != 0);
      arvalid = ($urandom_range(0, 1) != 0);
      araddr  = AW'($urandom_range(0, 3));
      bready  = ($urandom_range(0, 2) != 0);
      rready  = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
